pipeline_sequencer: RTL and testbench

Central stall/flush/halt controller for the five-stage pipeline (IF, OF, EX, MA, RW). It takes hazard and event indications from the stages and produces the per-latch enables, bubble inserts, PC write control and halt status that sequence the datapath. It also keeps saturating performance counters for cycles, stalls and flushes. The block sits beside `pipeline_top_module` and replaces the ad-hoc control logic currently spread across the stage latches.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/sat_counter.sv | 33 +++
 rtl/pipeline_sequencer.sv | 171 +++++++++++++++++
 tb/tb_pipeline_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer.
//   seq_state_t          : sequencer FSM state encoding (RUN, DRAIN, HALTED)
//   DEFAULT_DRAIN_CYCLES : cycles for the halt instruction to go from leaving OF to retiring from RW
//   NOP_INSN             : instruction word the stage latches load when a bubble is inserted
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } seq_state_t;

  localparam int DEFAULT_DRAIN_CYCLES = 3;

  // opcode 01101 with all operand fields zero
  localparam logic [31:0] NOP_INSN = 32'h6800_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, clears the count
//   clear  : synchronous clear
//   inc    : add one this cycle (ignored once the count is all ones)
//   count  : current count value
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Central stall/flush/halt controller for the IF-OF-EX-MA-RW pipeline.
//   clk                : clock, rising edge
//   reset              : asynchronous active-low reset
//   is_Branch_Taken    : branch resolved taken in EX
//   isDataInterLock    : load-use hazard on the instruction in OF
//   isLastInstruction  : halt instruction present in OF
//   mem_busy           : MA access outstanding, freeze the pipeline
//   pc_en, pc_sel_branch               : PC load enable and branch-target select
//   if_of_en, of_ex_en, ex_ma_en, ma_rw_en : pipeline latch enables
//   of_bubble, ex_bubble               : load a NOP into IF/OF resp. OF/EX
//   halted                             : pipeline drained after halt, sticky
//   cycle_count, stall_count, flush_count : saturating performance counters
// Control outputs are combinational from the registered state and the inputs.
module pipeline_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             is_Branch_Taken,
  input  logic             isDataInterLock,
  input  logic             isLastInstruction,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             pc_sel_branch,
  output logic             if_of_en,
  output logic             of_ex_en,
  output logic             ex_ma_en,
  output logic             ma_rw_en,
  output logic             of_bubble,
  output logic             ex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
  localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);

  seq_state_t    state_p1;
  logic [DW-1:0] drain_cnt_p1;

  logic halt_accept;
  logic cycle_inc;
  logic stall_inc;
  logic flush_inc;

  always_comb begin
    pc_en         = 1'b0;
    pc_sel_branch = 1'b0;
    if_of_en      = 1'b0;
    of_ex_en      = 1'b0;
    ex_ma_en      = 1'b0;
    ma_rw_en      = 1'b0;
    of_bubble     = 1'b0;
    ex_bubble     = 1'b0;
    halted        = 1'b0;
    halt_accept   = 1'b0;
    cycle_inc     = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    case (state_p1)
      RUN: begin
        cycle_inc = 1'b1;
        if (mem_busy) begin
          // full freeze; stages keep presenting their hazards until it lifts
          stall_inc = 1'b1;
        end else if (is_Branch_Taken) begin
          // wrong-path instructions in OF and EX are squashed, including a halt
          pc_en         = 1'b1;
          pc_sel_branch = 1'b1;
          if_of_en      = 1'b1;
          of_ex_en      = 1'b1;
          ex_ma_en      = 1'b1;
          ma_rw_en      = 1'b1;
          of_bubble     = 1'b1;
          ex_bubble     = 1'b1;
          flush_inc     = 1'b1;
        end else if (isDataInterLock) begin
          // hold IF and OF, send a bubble down into EX
          of_ex_en  = 1'b1;
          ex_ma_en  = 1'b1;
          ma_rw_en  = 1'b1;
          ex_bubble = 1'b1;
          stall_inc = 1'b1;
        end else begin
          pc_en       = 1'b1;
          if_of_en    = 1'b1;
          of_ex_en    = 1'b1;
          ex_ma_en    = 1'b1;
          ma_rw_en    = 1'b1;
          halt_accept = isLastInstruction;
        end
      end
      DRAIN: begin
        cycle_inc = 1'b1;
        if (mem_busy) begin
          stall_inc = 1'b1;
        end else begin
          // keep feeding NOPs behind the halt while it retires
          if_of_en  = 1'b1;
          of_ex_en  = 1'b1;
          ex_ma_en  = 1'b1;
          ma_rw_en  = 1'b1;
          of_bubble = 1'b1;
        end
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: ;
    endcase
  end

  // state register: control only
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p1     <= RUN;
      drain_cnt_p1 <= '0;
    end else begin
      case (state_p1)
        RUN: begin
          if (halt_accept) begin
            state_p1     <= DRAIN;
            drain_cnt_p1 <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (!mem_busy) begin
            if (drain_cnt_p1 == '0) begin
              state_p1 <= HALTED;
            end else begin
              drain_cnt_p1 <= drain_cnt_p1 - DRAIN_ONE;
            end
          end
        end
        HALTED: ;
        default: state_p1 <= RUN;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clear (1'b0),
    .inc   (cycle_inc),
    .count (cycle_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clear (1'b0),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clear (1'b0),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: a 32-bit-counter instance and a 4-bit-counter
// instance share the same stimulus and are checked every cycle against a
// behavioural model, plus directed literal checks.
module tb_pipeline_sequencer;

  localparam int DRAIN = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic br = 1'b0, il = 1'b0, last = 1'b0, mb = 1'b0;

  logic a_pc_en, a_sel, a_ifof, a_ofex, a_exma, a_marw, a_ob, a_eb, a_halted;
  logic [31:0] a_cycle, a_stall, a_flush;
  logic b_pc_en, b_sel, b_ifof, b_ofex, b_exma, b_marw, b_ob, b_eb, b_halted;
  logic [3:0] b_cycle, b_stall, b_flush;

  pipeline_sequencer #(.DRAIN_CYCLES(DRAIN), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .is_Branch_Taken(br), .isDataInterLock(il),
    .isLastInstruction(last), .mem_busy(mb),
    .pc_en(a_pc_en), .pc_sel_branch(a_sel), .if_of_en(a_ifof), .of_ex_en(a_ofex),
    .ex_ma_en(a_exma), .ma_rw_en(a_marw), .of_bubble(a_ob), .ex_bubble(a_eb),
    .halted(a_halted), .cycle_count(a_cycle), .stall_count(a_stall), .flush_count(a_flush)
  );

  pipeline_sequencer #(.DRAIN_CYCLES(DRAIN), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .is_Branch_Taken(br), .isDataInterLock(il),
    .isLastInstruction(last), .mem_busy(mb),
    .pc_en(b_pc_en), .pc_sel_branch(b_sel), .if_of_en(b_ifof), .of_ex_en(b_ofex),
    .ex_ma_en(b_exma), .ma_rw_en(b_marw), .of_bubble(b_ob), .ex_bubble(b_eb),
    .halted(b_halted), .cycle_count(b_cycle), .stall_count(b_stall), .flush_count(b_flush)
  );

  always #5 clk = ~clk;

  logic [8:0] a_ctrl, b_ctrl;
  assign a_ctrl = {a_pc_en, a_sel, a_ifof, a_ofex, a_exma, a_marw, a_ob, a_eb, a_halted};
  assign b_ctrl = {b_pc_en, b_sel, b_ifof, b_ofex, b_exma, b_marw, b_ob, b_eb, b_halted};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Unbounded event counts; each instance sees them clipped to its width.
  longint m_cyc = 0, m_stl = 0, m_fls = 0;
  bit     m_drain = 0, m_halt = 0;
  int     m_done = 0;   // unfrozen drain cycles completed so far

  function automatic longint clip(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // {pc_en, pc_sel, if_of, of_ex, ex_ma, ma_rw, of_bubble, ex_bubble, halted}
  function automatic logic [8:0] exp_ctrl();
    if (m_halt)  return 9'b0_0_0000_00_1;
    if (mb)      return 9'b0_0_0000_00_0;
    if (m_drain) return 9'b0_0_1111_10_0;
    if (br)      return 9'b1_1_1111_11_0;
    if (il)      return 9'b0_0_0111_01_0;
    return 9'b1_0_1111_00_0;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      m_cyc = 0; m_stl = 0; m_fls = 0;
      m_drain = 0; m_halt = 0; m_done = 0;
    end
    chk("ctrl32", a_ctrl, exp_ctrl());
    chk("ctrl4", b_ctrl, exp_ctrl());
    chk("cycle32", a_cycle, clip(m_cyc, 32));
    chk("stall32", a_stall, clip(m_stl, 32));
    chk("flush32", a_flush, clip(m_fls, 32));
    chk("cycle4", b_cycle, clip(m_cyc, 4));
    chk("stall4", b_stall, clip(m_stl, 4));
    chk("flush4", b_flush, clip(m_fls, 4));
    // advance the model to what the next rising edge produces
    if (reset && !m_halt) begin
      m_cyc++;
      if (mb) m_stl++;
      else if (m_drain) begin
        m_done++;
        if (m_done == DRAIN) begin m_drain = 0; m_halt = 1; end
      end
      else if (br) m_fls++;
      else if (il) m_stl++;
      else if (last) begin m_drain = 1; m_done = 0; end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic set_in(input logic b, input logic i, input logic l, input logic m);
    br = b; il = i; last = l; mb = m;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    longint frozen;

    // reset held: RUN outputs with idle inputs, counters zero
    set_in(0, 0, 0, 0);
    repeat (3) tick();
    chk("reset_ctrl", a_ctrl, 9'b1_0_1111_00_0);
    chk("reset_cycle", a_cycle, 0);
    reset = 1'b1;
    repeat (10) tick();
    chk("idle10_cycle", a_cycle, 10);

    // single taken branch
    set_in(1, 0, 0, 0); #1;
    chk("br_ctrl", a_ctrl, 9'b1_1_1111_11_0);
    tick();
    chk("br_flush", a_flush, 1);

    // branch with simultaneous interlock: identical response, no stall
    set_in(1, 1, 0, 0); #1;
    chk("br_il_ctrl", a_ctrl, 9'b1_1_1111_11_0);
    tick();
    chk("br_il_flush", a_flush, 2);
    chk("br_il_stall", a_stall, 0);

    // two-cycle interlock
    for (int k = 0; k < 2; k++) begin
      set_in(0, 1, 0, 0); #1;
      chk("il_ctrl", a_ctrl, 9'b0_0_0111_01_0);
      tick();
    end
    chk("il_stall", a_stall, 2);

    // halt accepted, drain with branch/interlock ignored in first drain cycle
    set_in(0, 0, 1, 0); #1;
    chk("last_ctrl", a_ctrl, 9'b1_0_1111_00_0);
    tick();
    for (n = 0; n < 20 && !a_halted; n++) begin
      set_in(n == 0, n == 0, 0, 0); #1;
      chk("drain_pc_en", a_pc_en, 0);
      chk("drain_of_bubble", a_ob, 1);
      tick();
    end
    chk("drain_len", n, 3);
    chk("halt_cycle32", a_cycle, 18);
    chk("halt_cycle4_sat", b_cycle, 15);
    chk("halt_flush", a_flush, 2);
    frozen = a_cycle;
    set_in(1, 1, 1, 1);
    repeat (5) tick();
    chk("halted_sticky", a_halted, 1);
    chk("halted_cycle_frozen", a_cycle, frozen);

    // asynchronous reset from HALTED
    reset = 1'b0; #1;
    chk("async_clr_cycle", a_cycle, 0);
    chk("async_clr_halted", a_halted, 0);
    set_in(0, 0, 0, 0);
    tick();
    reset = 1'b1;

    // drain with two frozen cycles inside
    set_in(0, 0, 1, 0);
    tick();
    for (n = 0; n < 20 && !a_halted; n++) begin
      set_in(0, 0, 0, (n == 1) || (n == 2));
      tick();
    end
    chk("drain_mb_len", n, 5);
    chk("drain_mb_stall", a_stall, 2);
    chk("drain_mb_cycle", a_cycle, 6);

    reset = 1'b0;
    tick();
    reset = 1'b1;

    // halt on the wrong path of a taken branch
    set_in(1, 0, 1, 0); #1;
    chk("br_last_sel", a_sel, 1);
    tick();
    set_in(0, 0, 0, 0); #1;
    chk("br_last_run", a_pc_en, 1);
    chk("br_last_flush", a_flush, 1);
    repeat (4) tick();
    chk("br_last_not_halted", a_halted, 0);

    // freeze overrides a branch
    set_in(1, 0, 0, 1); #1;
    chk("mb_br_ctrl", a_ctrl, 9'b0_0_0000_00_0);
    tick();
    chk("mb_br_flush", a_flush, 1);
    chk("mb_br_stall", a_stall, 1);

    // reset asserted mid-drain
    set_in(0, 0, 1, 0);
    tick();
    set_in(0, 0, 0, 0);
    tick();
    chk("mid_drain_pc_en", a_pc_en, 0);
    reset = 1'b0; #1;
    chk("mid_drain_rst_cycle", a_cycle, 0);
    chk("mid_drain_rst_flush", a_flush, 0);
    chk("mid_drain_rst_pc_en", a_pc_en, 1);
    tick();
    reset = 1'b1;

    // long interlock: 4-bit stall counter saturates
    set_in(0, 1, 0, 0);
    repeat (20) tick();
    chk("long_il_stall32", a_stall, 20);
    chk("long_il_stall4_sat", b_stall, 15);
    set_in(0, 0, 0, 0);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
